pc_sequencer: RTL and testbench



---
 rtl/pc_seq_pkg.sv | 20 ++
 rtl/pc_sequencer_return_stack.sv | 44 ++++
 rtl/pc_sequencer.sv | 145 ++++++++++++++
 tb/tb_pc_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: op codes and FSM states.
package pc_seq_pkg;

  // Decoded control-flow op codes (7 is reserved and behaves as NOP).
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_JZ   = 3'd2;
  localparam logic [2:0] OP_JNZ  = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;

  // Sequencer states. FAULT is terminal until reset.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Return-address LIFO. Entry 0 is always the top of stack, so the popped value
// is available combinationally without indexing by the depth counter.
// Requests that would overflow or underflow are dropped; the caller decides faults.
module return_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int DW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  assign dout  = mem[0];
  assign full  = (depth == DEPTH_MAX);
  assign empty = (depth == '0);

  // Shift-register stack: push shifts entries down, pop shifts them up.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      depth <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      for (int i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
      mem[0] <= din;
      depth  <= depth + 1'b1;
    end else if (pop && !empty) begin
      for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      mem[DEPTH-1] <= '0;
      depth        <= depth - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: turns one decoded control-flow op per cycle into a
// PC load enable/address, with a return-address stack, HALT/resume and a
// stack-fault trap. PC load outputs are combinational so an op in cycle N
// steers the PC at the edge ending cycle N.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                   PC_WIDTH     = 8,
  parameter int                   STACK_DEPTH  = 4,
  parameter logic [PC_WIDTH-1:0]  FAULT_VECTOR = 8'hF0,
  localparam int                  SDW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                op_valid,
  input  logic [2:0]          op_code,
  input  logic [PC_WIDTH-1:0] op_target,
  input  logic                zero_flag,
  input  logic                resume,
  output logic                pc_wr_en,
  output logic [PC_WIDTH-1:0] pc_load_addr,
  output logic                halted,
  output logic                stack_err,
  output logic [SDW-1:0]      stack_depth,
  output seq_state_e          dbg_state
);

  seq_state_e          state;
  seq_state_e          state_nxt;
  logic [PC_WIDTH-1:0] hold_addr;
  logic                capture_hold;
  logic                set_err;
  logic                push;
  logic                pop;
  logic [PC_WIDTH-1:0] stk_dout;
  logic                stk_full;
  logic                stk_empty;

  assign halted    = (state == ST_HALT);
  assign dbg_state = state;

  return_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .res_n (res_n),
    .push  (push),
    .pop   (pop),
    .din   (pc + PC_WIDTH'(1)),
    .dout  (stk_dout),
    .depth (stack_depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Decode op against current state into PC load, stack request and next state.
  always_comb begin
    pc_wr_en     = 1'b0;
    pc_load_addr = '0;
    push         = 1'b0;
    pop          = 1'b0;
    set_err      = 1'b0;
    capture_hold = 1'b0;
    state_nxt    = state;
    case (state)
      ST_RUN: begin
        if (op_valid) begin
          case (op_code)
            OP_JMP: begin
              pc_wr_en     = 1'b1;
              pc_load_addr = op_target;
            end
            OP_JZ, OP_JNZ: begin
              // JZ takes on zero, JNZ on non-zero.
              if (zero_flag == (op_code == OP_JZ)) begin
                pc_wr_en     = 1'b1;
                pc_load_addr = op_target;
              end
            end
            OP_CALL: begin
              pc_wr_en = 1'b1;
              if (!stk_full) begin
                push         = 1'b1;
                pc_load_addr = op_target;
              end else begin
                pc_load_addr = FAULT_VECTOR;
                set_err      = 1'b1;
                state_nxt    = ST_FAULT;
              end
            end
            OP_RET: begin
              pc_wr_en = 1'b1;
              if (!stk_empty) begin
                pop          = 1'b1;
                pc_load_addr = stk_dout;
              end else begin
                pc_load_addr = FAULT_VECTOR;
                set_err      = 1'b1;
                state_nxt    = ST_FAULT;
              end
            end
            OP_HALT: begin
              // Reload PC with itself so it stops advancing.
              pc_wr_en     = 1'b1;
              pc_load_addr = pc;
              capture_hold = 1'b1;
              state_nxt    = ST_HALT;
            end
            default: ;
          endcase
        end
      end
      ST_HALT: begin
        // On resume let the PC increment past the held address.
        if (resume) begin
          state_nxt = ST_RUN;
        end else begin
          pc_wr_en     = 1'b1;
          pc_load_addr = hold_addr;
        end
      end
      ST_FAULT: begin
        pc_wr_en     = 1'b1;
        pc_load_addr = FAULT_VECTOR;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // State, held PC and sticky stack error register.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= ST_RUN;
      hold_addr <= '0;
      stack_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture_hold) hold_addr <= pc;
      if (set_err) stack_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural program counter in the loop.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic       clk = 1'b0;
  logic       res_n;
  logic [7:0] pc;
  logic       op_valid;
  logic [2:0] op_code;
  logic [7:0] op_target;
  logic       zero_flag;
  logic       resume;
  logic       pc_wr_en;
  logic [7:0] pc_load_addr;
  logic       halted;
  logic       stack_err;
  logic [2:0] stack_depth;
  seq_state_e dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer dut (
    .clk          (clk),
    .res_n        (res_n),
    .pc           (pc),
    .op_valid     (op_valid),
    .op_code      (op_code),
    .op_target    (op_target),
    .zero_flag    (zero_flag),
    .resume       (resume),
    .pc_wr_en     (pc_wr_en),
    .pc_load_addr (pc_load_addr),
    .halted       (halted),
    .stack_err    (stack_err),
    .stack_depth  (stack_depth),
    .dbg_state    (dbg_state)
  );

  // Clock and program counter model: loads on pc_wr_en, otherwise increments.
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) pc <= 8'h00;
    else if (pc_wr_en) pc <= pc_load_addr;
    else pc <= pc + 8'h01;
  end

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic set_op(input logic v, input logic [2:0] c, input logic [7:0] t,
                        input logic zf, input logic rs);
    op_valid  = v;
    op_code   = c;
    op_target = t;
    zero_flag = zf;
    resume    = rs;
    #1;
  endtask

  task automatic idle();
    set_op(1'b0, OP_NOP, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk_pc(input string name, input logic [7:0] exp);
    n_cmp++;
    if (pc !== exp) begin
      n_err++;
      $display("FAIL %s: pc got %h expected %h", name, pc, exp);
    end
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    idle();
    #7;
    n_cmp++;
    if ({pc_wr_en, pc_load_addr, halted, stack_err, stack_depth} !== 14'd0 || dbg_state !== ST_RUN) begin
      n_err++;
      $display("FAIL reset_outputs: wr=%b addr=%h halted=%b err=%b depth=%0d state=%0d expected all zero/RUN",
               pc_wr_en, pc_load_addr, halted, stack_err, stack_depth, dbg_state);
    end
    @(negedge clk);
    res_n = 1'b1;
    #1;
    chk_pc("free_run_0", 8'h00);
    tick();
    chk_pc("free_run_1", 8'h01);
    tick();
    chk_pc("free_run_2", 8'h02);
  endtask

  task automatic test_jmp();
    set_op(1'b1, OP_JMP, 8'h20, 1'b0, 1'b0);
    n_cmp++;
    if (pc_wr_en !== 1'b1 || pc_load_addr !== 8'h20) begin
      n_err++;
      $display("FAIL jmp_load: wr=%b addr=%h expected 1/20", pc_wr_en, pc_load_addr);
    end
    tick();
    idle();
    chk_pc("jmp_pc", 8'h20);
    tick();
    chk_pc("jmp_next", 8'h21);
  endtask

  task automatic test_cond();
    set_op(1'b1, OP_JZ, 8'h50, 1'b0, 1'b0);
    n_cmp++;
    if (pc_wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL jz_not_taken_wr: got %b expected 0", pc_wr_en);
    end
    tick();
    chk_pc("jz_not_taken", 8'h22);
    set_op(1'b1, OP_JNZ, 8'h50, 1'b0, 1'b0);
    tick();
    idle();
    chk_pc("jnz_taken", 8'h50);
  endtask

  task automatic test_call_ret();
    set_op(1'b1, OP_JMP, 8'h10, 1'b0, 1'b0);
    tick();
    set_op(1'b1, OP_CALL, 8'h40, 1'b0, 1'b0);
    tick();
    idle();
    chk_pc("call_pc", 8'h40);
    n_cmp++;
    if (stack_depth !== 3'd1) begin
      n_err++;
      $display("FAIL call_depth: got %0d expected 1", stack_depth);
    end
    tick();
    set_op(1'b1, OP_RET, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (pc_wr_en !== 1'b1 || pc_load_addr !== 8'h11) begin
      n_err++;
      $display("FAIL ret_load: wr=%b addr=%h expected 1/11", pc_wr_en, pc_load_addr);
    end
    tick();
    idle();
    chk_pc("ret_pc", 8'h11);
    n_cmp++;
    if (stack_depth !== 3'd0) begin
      n_err++;
      $display("FAIL ret_depth: got %0d expected 0", stack_depth);
    end
    // Return address of a CALL at 0xFF wraps to 0x00.
    set_op(1'b1, OP_JMP, 8'hFF, 1'b0, 1'b0);
    tick();
    set_op(1'b1, OP_CALL, 8'h60, 1'b0, 1'b0);
    tick();
    set_op(1'b1, OP_RET, 8'h00, 1'b0, 1'b0);
    tick();
    idle();
    chk_pc("call_wrap", 8'h00);
  endtask

  task automatic test_halt();
    set_op(1'b1, OP_JMP, 8'h30, 1'b0, 1'b0);
    tick();
    set_op(1'b1, OP_HALT, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (pc_wr_en !== 1'b1 || pc_load_addr !== 8'h30) begin
      n_err++;
      $display("FAIL halt_load: wr=%b addr=%h expected 1/30", pc_wr_en, pc_load_addr);
    end
    tick();
    // A JMP presented in HALT without resume must be ignored too.
    set_op(1'b1, OP_JMP, 8'h77, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk_pc("halt_hold", 8'h30);
      n_cmp++;
      if (halted !== 1'b1) begin
        n_err++;
        $display("FAIL halt_flag: got %b expected 1 (cycle %0d)", halted, i);
      end
      tick();
    end
    set_op(1'b1, OP_JMP, 8'h80, 1'b0, 1'b1);
    n_cmp++;
    if (halted !== 1'b1 || pc_wr_en !== 1'b0) begin
      n_err++;
      $display("FAIL resume_cycle: halted=%b wr=%b expected 1/0", halted, pc_wr_en);
    end
    tick();
    idle();
    chk_pc("resume_pc", 8'h31);
    n_cmp++;
    if (halted !== 1'b0) begin
      n_err++;
      $display("FAIL resume_halted: got %b expected 0", halted);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] tgt;
    for (int i = 0; i < 4; i++) begin
      tgt = 8'h40 + 8'(i * 16);
      set_op(1'b1, OP_CALL, tgt, 1'b0, 1'b0);
      tick();
      chk_pc("nest_call", tgt);
    end
    n_cmp++;
    if (stack_depth !== 3'd4) begin
      n_err++;
      $display("FAIL nest_depth: got %0d expected 4", stack_depth);
    end
    set_op(1'b1, OP_CALL, 8'h90, 1'b0, 1'b0);
    n_cmp++;
    if (pc_wr_en !== 1'b1 || pc_load_addr !== 8'hF0) begin
      n_err++;
      $display("FAIL ovf_load: wr=%b addr=%h expected 1/f0", pc_wr_en, pc_load_addr);
    end
    tick();
    set_op(1'b1, OP_JMP, 8'h12, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk_pc("fault_hold", 8'hF0);
      n_cmp++;
      if (stack_err !== 1'b1 || stack_depth !== 3'd4 || halted !== 1'b0 || dbg_state !== ST_FAULT) begin
        n_err++;
        $display("FAIL fault_status: err=%b depth=%0d halted=%b state=%0d expected 1/4/0/FAULT",
                 stack_err, stack_depth, halted, dbg_state);
      end
      tick();
    end
  endtask

  task automatic reset_mid_fault(input string name);
    res_n = 1'b0;
    idle();
    n_cmp++;
    if (stack_err !== 1'b0 || pc_wr_en !== 1'b0 || dbg_state !== ST_RUN || stack_depth !== 3'd0) begin
      n_err++;
      $display("FAIL %s: err=%b wr=%b state=%0d depth=%0d expected 0/0/RUN/0",
               name, stack_err, pc_wr_en, dbg_state, stack_depth);
    end
    @(negedge clk);
    res_n = 1'b1;
    #1;
  endtask

  task automatic test_underflow();
    reset_mid_fault("reset_after_ovf");
    chk_pc("post_reset_0", 8'h00);
    tick();
    set_op(1'b1, OP_RET, 8'h00, 1'b0, 1'b0);
    n_cmp++;
    if (pc_wr_en !== 1'b1 || pc_load_addr !== 8'hF0) begin
      n_err++;
      $display("FAIL udf_load: wr=%b addr=%h expected 1/f0", pc_wr_en, pc_load_addr);
    end
    tick();
    idle();
    chk_pc("udf_pc", 8'hF0);
    n_cmp++;
    if (stack_err !== 1'b1) begin
      n_err++;
      $display("FAIL udf_err: got %b expected 1", stack_err);
    end
    tick();
    reset_mid_fault("reset_after_udf");
    chk_pc("count_0", 8'h00);
    tick();
    chk_pc("count_1", 8'h01);
    tick();
    chk_pc("count_2", 8'h02);
  endtask

  initial begin
    test_reset();
    test_jmp();
    test_cond();
    test_call_ret();
    test_halt();
    test_overflow();
    test_underflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
